canv_disp_unpack: RTL and testbench



---
 rtl/canv_disp_unpack_if.sv | 40 ++++
 rtl/canv_disp_unpack.sv | 110 +++++++++++
 tb/tb_canv_disp_unpack.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/canv_disp_unpack_if.sv
// Canvas display unpacker bus.
// Groups the per-pixel signals flowing from the display AGU / VRAM read port
// into the unpacker, together with the colour index results heading to the CLUT.
//   pix_id     : pixel ID within the packed word (from AGU)
//   paint      : canvas painting enable (from AGU)
//   addr_shift : address shift, log2(pixels per word)
//   vram_data  : VRAM read data, aligned VRAM_LAT cycles after the AGU address
//   trans_en   : transparency keying enable
//   trans_idx  : transparent colour index
//   cidx       : colour index to the CLUT
//   cidx_valid : cidx belongs to a painted canvas pixel
//   opaque     : painted and not keyed out as transparent
// The master modport is the upstream side (AGU/VRAM/control plus CLUT sink).
// The slave modport is the unpacker itself.
interface canv_disp_unpack_if #(
  parameter int WORD    = 32,
  parameter int PIX_IDW = $clog2(WORD),
  parameter int SHIFTW  = 3,
  parameter int CIDXW   = 8
);
  logic [PIX_IDW-1:0] pix_id;
  logic               paint;
  logic [SHIFTW-1:0]  addr_shift;
  logic [WORD-1:0]    vram_data;
  logic               trans_en;
  logic [CIDXW-1:0]   trans_idx;
  logic [CIDXW-1:0]   cidx;
  logic               cidx_valid;
  logic               opaque;

  modport master (
    output pix_id, paint, addr_shift, vram_data, trans_en, trans_idx,
    input  cidx, cidx_valid, opaque
  );

  modport slave (
    input  pix_id, paint, addr_shift, vram_data, trans_en, trans_idx,
    output cidx, cidx_valid, opaque
  );
endinterface

// File: rtl/canv_disp_unpack.sv
// Canvas display pixel unpacker.
// Delays the AGU's {pix_id, addr_shift, paint} through a VRAM_LAT-deep line so
// that they line up with the VRAM read data, extracts the addressed pixel from
// the packed word as a colour index, and flags transparent pixels.
// Ports:
//   clk_pix   : pixel clock
//   rst_pix_n : asynchronous active-low reset
//   bus       : slave side of canv_disp_unpack_if (inputs from AGU/VRAM,
//               cidx / cidx_valid / opaque outputs to the CLUT)
// Output latency is VRAM_LAT+1 cycles from pix_id/paint, one pixel per clock.
module canv_disp_unpack #(
  parameter int WORD     = 32,
  parameter int PIX_IDW  = $clog2(WORD),
  parameter int SHIFTW   = 3,
  parameter int VRAM_LAT = 1,
  parameter int CIDXW    = 8
) (
  input  logic                  clk_pix,
  input  logic                  rst_pix_n,
  canv_disp_unpack_if.slave     bus
);

  logic [PIX_IDW-1:0] pixId_q [VRAM_LAT];
  logic [SHIFTW-1:0]  shift_q [VRAM_LAT];
  logic               paint_q [VRAM_LAT];

  logic [PIX_IDW-1:0] alPixId;
  logic [SHIFTW-1:0]  alShift;
  logic               alPaint;

  logic [31:0]        effShift;
  logic [31:0]        bpp;
  logic [PIX_IDW-1:0] pid;
  logic [31:0]        bitOff;
  logic [WORD-1:0]    fieldMask;
  logic [CIDXW-1:0]   extIdx;

  logic [CIDXW-1:0]   cidx_d, cidx_q;
  logic               valid_d, valid_q;
  logic               opaque_d, opaque_q;

  // Alignment delay line: stage 0 captures the AGU outputs, every later stage
  // copies its predecessor each clock. There is no stall, so the last stage
  // always holds the pixel whose VRAM word is arriving this cycle.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      for (int k = 0; k < VRAM_LAT; k++) begin
        pixId_q[k] <= '0;
        shift_q[k] <= '0;
        paint_q[k] <= 1'b0;
      end
    end else begin
      pixId_q[0] <= bus.pix_id;
      shift_q[0] <= bus.addr_shift;
      paint_q[0] <= bus.paint;
      for (int k = 1; k < VRAM_LAT; k++) begin
        pixId_q[k] <= pixId_q[k-1];
        shift_q[k] <= shift_q[k-1];
        paint_q[k] <= paint_q[k-1];
      end
    end
  end

  assign alPixId = pixId_q[VRAM_LAT-1];
  assign alShift = shift_q[VRAM_LAT-1];
  assign alPaint = paint_q[VRAM_LAT-1];

  // Pixel extraction from the aligned stage. Shifts beyond PIX_IDW clamp to
  // 1 bpp. Only the low s bits of pix_id select the pixel, so pid*bpp always
  // stays inside the word. A full-width field (s=0) needs an explicit all-ones
  // mask because 1<<WORD does not fit at WORD width.
  always_comb begin
    effShift = 32'(alShift);
    if (effShift > 32'(PIX_IDW)) begin
      effShift = 32'(PIX_IDW);
    end
    bpp       = 32'(WORD) >> effShift;
    pid       = alPixId & PIX_IDW'((32'd1 << effShift) - 32'd1);
    bitOff    = 32'(pid) * bpp;
    fieldMask = (bpp >= 32'(WORD)) ? '1 : ((WORD'(1) << bpp) - WORD'(1));
    extIdx    = CIDXW'((bus.vram_data >> bitOff) & fieldMask);
  end

  // Next output values. Unpainted pixels force everything to zero so VRAM
  // contents never leak out. Transparency keying uses the live trans_en and
  // trans_idx rather than delayed copies.
  always_comb begin
    valid_d  = alPaint;
    cidx_d   = alPaint ? extIdx : '0;
    opaque_d = alPaint && !(bus.trans_en && (extIdx == bus.trans_idx));
  end

  // Output register, loaded every pixel clock.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      cidx_q   <= '0;
      valid_q  <= 1'b0;
      opaque_q <= 1'b0;
    end else begin
      cidx_q   <= cidx_d;
      valid_q  <= valid_d;
      opaque_q <= opaque_d;
    end
  end

  assign bus.cidx       = cidx_q;
  assign bus.cidx_valid = valid_q;
  assign bus.opaque     = opaque_q;

endmodule

// File: tb/tb_canv_disp_unpack.sv
// Testbench for canv_disp_unpack.
// Two instances share the clock and reset: busA/dutA with VRAM_LAT=1 and
// busB/dutB with VRAM_LAT=3. Directed vectors with hand-computed indices are
// queued per segment and streamed back-to-back. For each vector the VRAM word
// and transparency settings are presented VRAM_LAT cycles after its pix_id,
// which matches the real VRAM read timing.
module tb_canv_disp_unpack;

  localparam int WORD    = 32;
  localparam int PIX_IDW = 5;
  localparam int SHIFTW  = 3;
  localparam int CIDXW   = 8;

  typedef struct {
    logic [4:0]  pix;
    logic        paint;
    logic [2:0]  sh;
    logic [31:0] vram;
    logic        ten;
    logic [7:0]  tidx;
    logic [7:0]  eC;
    logic        eV;
    logic        eO;
  } entry_t;

  logic   clk_pix   = 1'b0;
  logic   rst_pix_n = 1'b0;
  int     total     = 0;
  int     bad       = 0;
  entry_t seq[$];

  canv_disp_unpack_if #(.WORD(WORD), .PIX_IDW(PIX_IDW), .SHIFTW(SHIFTW), .CIDXW(CIDXW)) busA ();
  canv_disp_unpack_if #(.WORD(WORD), .PIX_IDW(PIX_IDW), .SHIFTW(SHIFTW), .CIDXW(CIDXW)) busB ();

  canv_disp_unpack #(.WORD(WORD), .PIX_IDW(PIX_IDW), .SHIFTW(SHIFTW), .VRAM_LAT(1), .CIDXW(CIDXW)) dutA (
    .clk_pix   (clk_pix),
    .rst_pix_n (rst_pix_n),
    .bus       (busA)
  );

  canv_disp_unpack #(.WORD(WORD), .PIX_IDW(PIX_IDW), .SHIFTW(SHIFTW), .VRAM_LAT(3), .CIDXW(CIDXW)) dutB (
    .clk_pix   (clk_pix),
    .rst_pix_n (rst_pix_n),
    .bus       (busB)
  );

  // Free-running pixel clock, 10 time units per cycle.
  always #5 clk_pix = ~clk_pix;

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic applyStimulus(input int lat, input logic [4:0] pix, input logic paint,
                               input logic [2:0] sh, input logic [31:0] vram,
                               input logic ten, input logic [7:0] tidx);
    if (lat == 1) begin
      busA.pix_id     = pix;
      busA.paint      = paint;
      busA.addr_shift = sh;
      busA.vram_data  = vram;
      busA.trans_en   = ten;
      busA.trans_idx  = tidx;
    end else begin
      busB.pix_id     = pix;
      busB.paint      = paint;
      busB.addr_shift = sh;
      busB.vram_data  = vram;
      busB.trans_en   = ten;
      busB.trans_idx  = tidx;
    end
  endtask

  task automatic checkOutput(input string tag, input int lat, input logic [7:0] eC,
                             input logic eV, input logic eO);
    logic [7:0] c;
    logic       v;
    logic       o;
    if (lat == 1) begin
      c = busA.cidx;
      v = busA.cidx_valid;
      o = busA.opaque;
    end else begin
      c = busB.cidx;
      v = busB.cidx_valid;
      o = busB.opaque;
    end
    total++;
    assert (c === eC) else begin
      bad++;
      $error("[TB] FAIL %s cidx: got=%0h required=%0h", tag, c, eC);
    end
    total++;
    assert (v === eV) else begin
      bad++;
      $error("[TB] FAIL %s cidx_valid: got=%0b required=%0b", tag, v, eV);
    end
    total++;
    assert (o === eO) else begin
      bad++;
      $error("[TB] FAIL %s opaque: got=%0b required=%0b", tag, o, eO);
    end
  endtask

  task automatic addE(input logic [4:0] pix, input logic paint, input logic [2:0] sh,
                      input logic [31:0] vram, input logic ten, input logic [7:0] tidx,
                      input logic [7:0] eC, input logic eV, input logic eO);
    entry_t e;
    e.pix = pix; e.paint = paint; e.sh = sh; e.vram = vram;
    e.ten = ten; e.tidx = tidx; e.eC = eC; e.eV = eV; e.eO = eO;
    seq.push_back(e);
  endtask

  // Streams the queued vectors into one instance. Iteration i feeds vector i
  // into the delay line and the VRAM word / keying of vector i-lat into the
  // aligned stage; after the edge the output holds vector i-lat. The first lat
  // outputs come from an idle pipeline and must be all zero.
  task automatic runSeq(input string tag, input int lat);
    int          n;
    entry_t      al;
    logic [4:0]  p;
    logic        pt;
    logic [2:0]  s;
    logic [31:0] vd;
    logic        te;
    logic [7:0]  ti;
    n = seq.size();
    for (int i = 0; i < n + lat; i++) begin
      p = 5'd0; pt = 1'b0; s = 3'd0; vd = 32'd0; te = 1'b0; ti = 8'd0;
      if (i < n) begin
        p = seq[i].pix; pt = seq[i].paint; s = seq[i].sh;
      end
      if (i >= lat) begin
        al = seq[i-lat];
        vd = al.vram; te = al.ten; ti = al.tidx;
      end
      applyStimulus(lat, p, pt, s, vd, te, ti);
      tick();
      if (i >= lat) begin
        checkOutput($sformatf("%s[%0d]", tag, i - lat), lat, al.eC, al.eV, al.eO);
      end else begin
        checkOutput($sformatf("%s.idle%0d", tag, i), lat, 8'h00, 1'b0, 1'b0);
      end
    end
    seq.delete();
  endtask

  initial begin
    logic [7:0] bits1bpp [8];
    bits1bpp = '{8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd1};

    applyStimulus(1, 5'd0, 1'b0, 3'd0, 32'd0, 1'b0, 8'd0);
    applyStimulus(3, 5'd0, 1'b0, 3'd0, 32'd0, 1'b0, 8'd0);

    // Reset state while rst_pix_n is held low.
    repeat (2) tick();
    checkOutput("resetA", 1, 8'h00, 1'b0, 1'b0);
    checkOutput("resetB", 3, 8'h00, 1'b0, 1'b0);
    @(negedge clk_pix);
    rst_pix_n = 1'b1;
    tick();

    // 4 bpp: nibble i of 0x76543210 is i.
    for (int i = 0; i < 8; i++) addE(5'(i), 1'b1, 3'd3, 32'h76543210, 1'b0, 8'h00, 8'(i), 1'b1, 1'b1);
    runSeq("bpp4", 1);

    // 1 bpp, then the same with an over-range shift that clamps to 1 bpp.
    for (int i = 0; i < 8; i++) addE(5'(i), 1'b1, 3'd5, 32'hA5A5A5A5, 1'b0, 8'h00, bits1bpp[i], 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) addE(5'(i), 1'b1, 3'd7, 32'hA5A5A5A5, 1'b0, 8'h00, bits1bpp[i], 1'b1, 1'b1);
    runSeq("bpp1", 1);

    // 32 bpp truncated to 8 bits, 16 bpp with pix_id masking, 2 bpp zero-extended.
    addE(5'h1F, 1'b1, 3'd0, 32'h123456F0, 1'b0, 8'h00, 8'hF0, 1'b1, 1'b1);
    addE(5'd0,  1'b1, 3'd1, 32'hBEEF1234, 1'b0, 8'h00, 8'h34, 1'b1, 1'b1);
    addE(5'd1,  1'b1, 3'd1, 32'hBEEF1234, 1'b0, 8'h00, 8'hEF, 1'b1, 1'b1);
    addE(5'd3,  1'b1, 3'd1, 32'hBEEF1234, 1'b0, 8'h00, 8'hEF, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) addE(5'(i), 1'b1, 3'd4, 32'h000000E4, 1'b0, 8'h00, 8'(i), 1'b1, 1'b1);
    runSeq("wide", 1);

    // 8 bpp transparency keying, then keying switched off mid-stream.
    addE(5'd0, 1'b1, 3'd2, 32'h44332211, 1'b1, 8'h33, 8'h11, 1'b1, 1'b1);
    addE(5'd1, 1'b1, 3'd2, 32'h44332211, 1'b1, 8'h33, 8'h22, 1'b1, 1'b1);
    addE(5'd2, 1'b1, 3'd2, 32'h44332211, 1'b1, 8'h33, 8'h33, 1'b1, 1'b0);
    addE(5'd3, 1'b1, 3'd2, 32'h44332211, 1'b1, 8'h33, 8'h44, 1'b1, 1'b1);
    addE(5'd0, 1'b1, 3'd2, 32'h44332211, 1'b0, 8'h33, 8'h11, 1'b1, 1'b1);
    addE(5'd1, 1'b1, 3'd2, 32'h44332211, 1'b0, 8'h33, 8'h22, 1'b1, 1'b1);
    addE(5'd2, 1'b1, 3'd2, 32'h44332211, 1'b0, 8'h33, 8'h33, 1'b1, 1'b1);
    addE(5'd3, 1'b1, 3'd2, 32'h44332211, 1'b0, 8'h33, 8'h44, 1'b1, 1'b1);
    runSeq("trans", 1);

    // Unpainted pixels ignore VRAM; paint toggling 1,0,1.
    addE(5'd3, 1'b0, 3'd3, 32'hFFFFFFFF, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    addE(5'd5, 1'b1, 3'd3, 32'h76543210, 1'b0, 8'h00, 8'h05, 1'b1, 1'b1);
    addE(5'd6, 1'b0, 3'd3, 32'hFFFFFFFF, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    addE(5'd7, 1'b1, 3'd3, 32'h76543210, 1'b0, 8'h00, 8'h07, 1'b1, 1'b1);
    runSeq("paint", 1);

    // VRAM_LAT=3 instance: a painting stream, then an asynchronous reset.
    applyStimulus(3, 5'd1, 1'b1, 3'd3, 32'h76543210, 1'b0, 8'h00);
    repeat (5) tick();
    checkOutput("lat3Pre", 3, 8'h01, 1'b1, 1'b1);
    #2;
    rst_pix_n = 1'b0;
    #1;
    checkOutput("rstAsync", 3, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("rstHold", 3, 8'h00, 1'b0, 1'b0);
    rst_pix_n = 1'b1;

    // After release: idle outputs until the first new pixel arrives, with a
    // 4 bpp -> 8 bpp -> 4 bpp shift change inside the stream.
    addE(5'd2, 1'b1, 3'd3, 32'h76543210, 1'b0, 8'h00, 8'h02, 1'b1, 1'b1);
    addE(5'd3, 1'b1, 3'd3, 32'h76543210, 1'b0, 8'h00, 8'h03, 1'b1, 1'b1);
    addE(5'd1, 1'b1, 3'd2, 32'h44332211, 1'b0, 8'h00, 8'h22, 1'b1, 1'b1);
    addE(5'd6, 1'b1, 3'd2, 32'h44332211, 1'b0, 8'h00, 8'h33, 1'b1, 1'b1);
    addE(5'd7, 1'b1, 3'd3, 32'h76543210, 1'b0, 8'h00, 8'h07, 1'b1, 1'b1);
    addE(5'd0, 1'b1, 3'd2, 32'h44332211, 1'b0, 8'h00, 8'h11, 1'b1, 1'b1);
    runSeq("lat3", 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
